// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_sequencer
// Purpose  : 65C02 reset/NMI/IRQ entry sequencer (push, vector fetch, WAI).
//            Optional WAIT state enabled by macro INTSEQ_WAI_EN.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_sequencer #(
   parameter int NMI_HIJACK = 1
) (
   input  logic       fclk,
   input  logic       reset,
   input  logic       step_en,
   input  logic       rdy,
   input  logic       resb,
   input  logic       nmib,
   input  logic       irqb,
   input  logic       i_flag,
   input  logic       instr_boundary,
   input  logic       wai_req,
   output logic       service_active,
   output logic       push_pch,
   output logic       push_pcl,
   output logic       push_psr,
   output logic       sp_dec,
   output logic [4:0] vector_operations,
   output logic       vpb,
   output logic       set_i,
   output logic       clr_d,
   output logic [1:0] source,
   output logic       wait_state
);

   localparam logic [1:0] c_SRC_NONE = 2'b00;
   localparam logic [1:0] c_SRC_IRQ  = 2'b01;
   localparam logic [1:0] c_SRC_NMI  = 2'b10;
   localparam logic [1:0] c_SRC_RST  = 2'b11;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      RST_HOLD = 4'd1,
      RST_STK  = 4'd2,
      PUSH_H   = 4'd3,
      PUSH_L   = 4'd4,
      PUSH_P   = 4'd5,
      VEC_L    = 4'd6,
      VEC_H    = 4'd7
`ifdef INTSEQ_WAI_EN
      , WAIT   = 4'd8
`endif
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [1:0] r_src;
   logic [1:0] w_src_nxt;
   logic       r_nmi_pend;
   logic       r_nmib_q;
   logic       w_nmi_edge;
   logic       w_nmi_clr;

   logic       w_service;
   logic       w_pch;
   logic       w_pcl;
   logic       w_psr;
   logic       w_sp_dec;
   logic [4:0] w_vec_ops;
   logic       w_vpb;
   logic       w_set_i;
   logic       w_wait;

`ifndef INTSEQ_WAI_EN
   logic       w_wai_unused;
   assign w_wai_unused = wai_req;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_src_nxt   = r_src;
      if (!resb) begin
         w_state_nxt = RST_HOLD;
         w_src_nxt   = c_SRC_RST;
      end else if (step_en && rdy) begin
         case (r_state)
            IDLE: begin
               if (instr_boundary && r_nmi_pend) begin
                  w_state_nxt = PUSH_H;
                  w_src_nxt   = c_SRC_NMI;
               end else if (instr_boundary && !irqb && !i_flag) begin
                  w_state_nxt = PUSH_H;
                  w_src_nxt   = c_SRC_IRQ;
               end
`ifdef INTSEQ_WAI_EN
               else if (wai_req) begin
                  w_state_nxt = WAIT;
               end
`endif
            end
            RST_HOLD: w_state_nxt = RST_STK;
            RST_STK:  w_state_nxt = VEC_L;
            PUSH_H:   w_state_nxt = PUSH_L;
            PUSH_L:   w_state_nxt = PUSH_P;
            PUSH_P: begin
               w_state_nxt = VEC_L;
               // Late NMI steals the vector fetch of an IRQ already pushed
               if ((NMI_HIJACK != 0) && (r_src == c_SRC_IRQ) && r_nmi_pend)
                  w_src_nxt = c_SRC_NMI;
            end
            VEC_L:    w_state_nxt = VEC_H;
            VEC_H: begin
               w_state_nxt = IDLE;
               w_src_nxt   = c_SRC_NONE;
            end
`ifdef INTSEQ_WAI_EN
            WAIT: begin
               if (r_nmi_pend) begin
                  w_state_nxt = PUSH_H;
                  w_src_nxt   = c_SRC_NMI;
               end else if (!irqb) begin
                  if (!i_flag) begin
                     w_state_nxt = PUSH_H;
                     w_src_nxt   = c_SRC_IRQ;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end
            end
`endif
            default: begin
               w_state_nxt = IDLE;
               w_src_nxt   = c_SRC_NONE;
            end
         endcase
      end
   end

   assign w_nmi_edge = r_nmib_q & ~nmib;
   assign w_nmi_clr  = (w_state_nxt == VEC_L) && (r_state != VEC_L) &&
                       (w_src_nxt == c_SRC_NMI);

   // Outputs decode the next state so the registered copy lines up with r_state
   always_comb begin
      w_service = 1'b1;
      w_pch     = 1'b0;
      w_pcl     = 1'b0;
      w_psr     = 1'b0;
      w_sp_dec  = 1'b0;
      w_vec_ops = 5'b00000;
      w_vpb     = 1'b1;
      w_set_i   = 1'b0;
      w_wait    = 1'b0;
      case (w_state_nxt)
         IDLE:    w_service = 1'b0;
         RST_STK: w_vec_ops = 5'b00001;
         PUSH_H: begin
            w_pch    = 1'b1;
            w_sp_dec = 1'b1;
         end
         PUSH_L: begin
            w_pcl    = 1'b1;
            w_sp_dec = 1'b1;
         end
         PUSH_P: begin
            w_psr    = 1'b1;
            w_sp_dec = 1'b1;
         end
         VEC_L: begin
            w_vpb     = 1'b0;
            w_vec_ops = {1'b1, w_src_nxt == c_SRC_RST, w_src_nxt == c_SRC_NMI,
                         w_src_nxt == c_SRC_IRQ, 1'b0};
         end
         VEC_H: begin
            w_vpb   = 1'b0;
            w_set_i = 1'b1;
         end
`ifdef INTSEQ_WAI_EN
         WAIT: begin
            w_service = 1'b0;
            w_wait    = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge fclk) begin
      if (reset) begin
         r_state           <= IDLE;
         r_src             <= c_SRC_NONE;
         r_nmi_pend        <= 1'b0;
         r_nmib_q          <= 1'b1;
         service_active    <= 1'b0;
         push_pch          <= 1'b0;
         push_pcl          <= 1'b0;
         push_psr          <= 1'b0;
         sp_dec            <= 1'b0;
         vector_operations <= 5'b00000;
         vpb               <= 1'b1;
         set_i             <= 1'b0;
         clr_d             <= 1'b0;
         source            <= c_SRC_NONE;
         wait_state        <= 1'b0;
      end else begin
         r_state           <= w_state_nxt;
         r_src             <= w_src_nxt;
         r_nmib_q          <= nmib;
         r_nmi_pend        <= w_nmi_edge | (r_nmi_pend & ~w_nmi_clr);
         service_active    <= w_service;
         push_pch          <= w_pch;
         push_pcl          <= w_pcl;
         push_psr          <= w_psr;
         sp_dec            <= w_sp_dec;
         vector_operations <= w_vec_ops;
         vpb               <= w_vpb;
         set_i             <= w_set_i;
         clr_d             <= w_set_i;
         source            <= w_src_nxt;
         wait_state        <= w_wait;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_sequencer
// Purpose  : Randomized self-checking bench; compares a hijacking and a
//            non-hijacking instance against a sequence-position model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_sequencer;

`ifdef INTSEQ_WAI_EN
   localparam bit c_WAI_EN = 1'b1;
`else
   localparam bit c_WAI_EN = 1'b0;
`endif

   logic fclk;
   logic reset, step_en, rdy, resb, nmib, irqb, i_flag, instr_boundary, wai_req;

   wire [15:0] obs [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic       service_active, push_pch, push_pcl, push_psr, sp_dec;
      logic [4:0] vector_operations;
      logic       vpb, set_i, clr_d, wait_state;
      logic [1:0] source;

      interrupt_sequencer #(.NMI_HIJACK((g == 0) ? 1 : 0)) u_dut (
         .fclk              (fclk),
         .reset             (reset),
         .step_en           (step_en),
         .rdy               (rdy),
         .resb              (resb),
         .nmib              (nmib),
         .irqb              (irqb),
         .i_flag            (i_flag),
         .instr_boundary    (instr_boundary),
         .wai_req           (wai_req),
         .service_active    (service_active),
         .push_pch          (push_pch),
         .push_pcl          (push_pcl),
         .push_psr          (push_psr),
         .sp_dec            (sp_dec),
         .vector_operations (vector_operations),
         .vpb               (vpb),
         .set_i             (set_i),
         .clr_d             (clr_d),
         .source            (source),
         .wait_state        (wait_state)
      );

      assign obs[g] = {service_active, push_pch, push_pcl, push_psr, sp_dec,
                       vector_operations, vpb, set_i, clr_d, source, wait_state};
   end

   initial fclk = 1'b0;
   always #5 fclk = ~fclk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: position in the entry sequence.
   // 0 idle, 1..3 push slots (3 = stack reset for a reset entry), 4 vector low,
   // 5 vector high, 6 reset held, 7 waiting for interrupt.
   int         m_pos  [2];
   logic [1:0] m_src  [2];
   bit         m_pend [2];
   bit         m_nq;

   function automatic logic [15:0] expect_out(input int pos, input logic [1:0] src);
      logic [4:0] vo;
      bit         rst;
      rst = (src == 2'b11);
      vo  = 5'b00000;
      if (pos == 3 && rst) vo = 5'b00001;
      if (pos == 4)        vo = {1'b1, rst, src == 2'b10, src == 2'b01, 1'b0};
      return {pos != 0 && pos != 7, pos == 1, pos == 2, pos == 3 && !rst,
              pos >= 1 && pos <= 3 && !rst, vo, !(pos == 4 || pos == 5),
              pos == 5, pos == 5, src, pos == 7};
   endfunction

   task automatic model_update();
      bit edge_seen;
      edge_seen = m_nq && !nmib;
      for (int k = 0; k < 2; k++) begin
         int         p;
         logic [1:0] s;
         bit         clr;
         p   = m_pos[k];
         s   = m_src[k];
         clr = 1'b0;
         if (reset) begin
            p         = 0;
            s         = 2'b00;
            m_pend[k] = 1'b0;
         end else begin
            if (!resb) begin
               p = 6;
               s = 2'b11;
            end else if (step_en && rdy) begin
               if (p == 0) begin
                  if (instr_boundary && m_pend[k]) begin
                     p = 1; s = 2'b10;
                  end else if (instr_boundary && !irqb && !i_flag) begin
                     p = 1; s = 2'b01;
                  end else if (c_WAI_EN && wai_req) begin
                     p = 7;
                  end
               end else if (p == 7) begin
                  if (m_pend[k]) begin
                     p = 1; s = 2'b10;
                  end else if (!irqb) begin
                     if (!i_flag) begin
                        p = 1; s = 2'b01;
                     end else begin
                        p = 0;
                     end
                  end
               end else if (p == 6) begin
                  p = 3;
               end else if (p == 5) begin
                  p = 0; s = 2'b00;
               end else begin
                  if (p == 3 && s == 2'b01 && k == 0 && m_pend[k]) s = 2'b10;
                  p = p + 1;
               end
               clr = (p == 4) && (m_pos[k] != 4) && (s == 2'b10);
            end
            m_pend[k] = edge_seen || (m_pend[k] && !clr);
         end
         m_pos[k] = p;
         m_src[k] = s;
      end
      m_nq = reset ? 1'b1 : nmib;
   endtask

   // Inputs are driven at the falling edge; outputs checked 1 ns after the rising edge.
   task automatic cyc(input string tag);
      @(posedge fclk);
      model_update();
      #1;
      check({tag, "/hij"},   obs[0], expect_out(m_pos[0], m_src[0]));
      check({tag, "/nohij"}, obs[1], expect_out(m_pos[1], m_src[1]));
      @(negedge fclk);
   endtask

   task automatic run_until_pos(input string tag, input int pos);
      for (int n = 0; n < 20 && m_pos[0] != pos; n++) cyc(tag);
   endtask

   initial begin
      reset = 1'b1; step_en = 1'b1; rdy = 1'b1; resb = 1'b1; nmib = 1'b1;
      irqb = 1'b1; i_flag = 1'b1; instr_boundary = 1'b0; wai_req = 1'b0;
      m_pos = '{0, 0}; m_src = '{2'b00, 2'b00}; m_pend = '{1'b0, 1'b0}; m_nq = 1'b1;
      @(negedge fclk);
      cyc("reset"); cyc("reset");
      reset = 1'b0;

      resb = 1'b0;
      repeat (3) cyc("resb_low");
      resb = 1'b1;
      repeat (5) cyc("resb_seq");

      i_flag = 1'b0; irqb = 1'b0; instr_boundary = 1'b1;
      cyc("irq_start");
      instr_boundary = 1'b0; irqb = 1'b1;
      repeat (6) cyc("irq_seq");

      i_flag = 1'b1; irqb = 1'b0; instr_boundary = 1'b1;
      repeat (20) cyc("irq_masked");
      nmib = 1'b0;
      repeat (8) cyc("nmi_seq");
      nmib = 1'b1;
      repeat (2) cyc("nmi_done");

      irqb = 1'b0; i_flag = 1'b0; instr_boundary = 1'b1;
      cyc("hij_start");
      irqb = 1'b1; instr_boundary = 1'b0;
      run_until_pos("hij_wait", 2);
      nmib = 1'b0;
      cyc("hij_edge");
      nmib = 1'b1; instr_boundary = 1'b1;
      repeat (12) cyc("hij_seq");

      irqb = 1'b0; i_flag = 1'b0; instr_boundary = 1'b1;
      cyc("frz_start");
      irqb = 1'b1; instr_boundary = 1'b0;
      run_until_pos("frz_wait", 2);
      rdy = 1'b0;
      repeat (4) cyc("rdy_freeze");
      rdy = 1'b1;
      repeat (6) cyc("frz_resume");
      irqb = 1'b0; instr_boundary = 1'b1;
      cyc("abort_start");
      irqb = 1'b1; instr_boundary = 1'b0;
      run_until_pos("abort_wait", 2);
      resb = 1'b0;
      repeat (2) cyc("abort_resb");
      resb = 1'b1;
      repeat (5) cyc("abort_recover");

      wai_req = 1'b1;
      cyc("wai_enter");
      wai_req = 1'b0;
      repeat (3) cyc("wai_hold");
      i_flag = 1'b1; irqb = 1'b0;
      cyc("wai_masked");
      irqb = 1'b1;
      repeat (3) cyc("wai_idle");
      wai_req = 1'b1;
      cyc("wai_enter2");
      wai_req = 1'b0; i_flag = 1'b0; irqb = 1'b0;
      cyc("wai_irq");
      irqb = 1'b1;
      repeat (6) cyc("wai_irq_seq");

      for (int n = 0; n < 4000; n++) begin
         reset          = ($urandom_range(0, 999) == 0);
         step_en        = ($urandom_range(0, 3) != 0);
         rdy            = ($urandom_range(0, 7) != 0);
         resb           = ($urandom_range(0, 59) != 0);
         nmib           = ($urandom_range(0, 11) != 0);
         irqb           = ($urandom_range(0, 2) != 0);
         i_flag         = ($urandom_range(0, 1) != 0);
         instr_boundary = ($urandom_range(0, 2) == 0);
         wai_req        = ($urandom_range(0, 9) == 0);
         cyc("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
